uart_rx_cmd_decoder: RTL and testbench

Frame parser that consumes the byte stream produced by the UART receive path and converts command frames into register-file accesses.
- Write frame: 0xAA, addr, data.
- Read frame: 0xBB, addr; the read result is returned as one byte on the UART transmit path.
- Sits between the UART RX outputs, the register file, and the UART TX inputs, all in the RX clock domain.

---
 rtl/uart_rx_cmd_decoder.sv | 150 +++++++++++++++
 tb/tb_uart_rx_cmd_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_decoder.sv
// Command frame parser: turns UART RX byte frames (AA addr data / BB addr) into
// register-file writes and reads, and returns read data on the UART TX path.
module uart_rx_cmd_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  RX_clk,
  input  logic                  RX_ARST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_DATA_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  input  logic                  TX_BUSY,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TXDATA_VALID,
  output logic                  CMD_BUSY,
  output logic                  FRM_ERR
);

  // state   | meaning
  // IDLE    | waiting for a command byte
  // WR_ADDR | write frame, waiting for address byte
  // WR_DATA | write frame, waiting for data byte
  // RD_ADDR | read frame, waiting for address byte
  // RD_WAIT | read issued, waiting for register-file data
  // TX_SEND | holding read data until the transmitter is free
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n, cnt_inc;
  logic                  acc, bad, timed, tmo;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wrdata_n, txd_n;
  logic                  wren_n, rden_n, txv_n, frm_n;

  assign acc     = RX_DATA_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
  assign bad     = RX_DATA_VLD & (RX_PAR_ERR | RX_STP_ERR);
  assign timed   = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) || (state == RD_WAIT);
  assign cnt_inc = cnt + CW'(1);
  assign tmo     = timed && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_n  = state;
    addr_n   = RF_Address;
    wrdata_n = RF_WrData;
    txd_n    = TX_P_DATA;
    wren_n   = 1'b0;
    rden_n   = 1'b0;
    txv_n    = 1'b0;
    frm_n    = 1'b0;
    // A byte (or read data) arriving on the timeout cycle takes priority over the abort.
    case (state)
      IDLE: begin
        if (acc) begin
          if (RX_P_DATA == CMD_WR)      state_n = WR_ADDR;
          else if (RX_P_DATA == CMD_RD) state_n = RD_ADDR;
          else                          frm_n   = 1'b1;
        end else if (bad) begin
          frm_n = 1'b1;
        end
      end
      WR_ADDR: begin
        if (acc) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end else if (bad || tmo) begin
          frm_n   = 1'b1;
          state_n = IDLE;
        end
      end
      WR_DATA: begin
        if (acc) begin
          wrdata_n = RX_P_DATA;
          wren_n   = 1'b1;
          state_n  = IDLE;
        end else if (bad || tmo) begin
          frm_n   = 1'b1;
          state_n = IDLE;
        end
      end
      RD_ADDR: begin
        if (acc) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rden_n  = 1'b1;
          state_n = RD_WAIT;
        end else if (bad || tmo) begin
          frm_n   = 1'b1;
          state_n = IDLE;
        end
      end
      RD_WAIT: begin
        if (RF_RdData_VLD) begin
          txd_n   = RF_RdData;
          state_n = TX_SEND;
        end else if (tmo) begin
          frm_n   = 1'b1;
          state_n = IDLE;
        end
      end
      TX_SEND: begin
        if (!TX_BUSY) begin
          txv_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    cnt_n = cnt_inc;
    if ((state_n != state) || acc || !timed) cnt_n = '0;
  end

  always_ff @(posedge RX_clk or posedge RX_ARST) begin
    if (RX_ARST) begin
      state        <= IDLE;
      cnt          <= '0;
      RF_Address   <= '0;
      RF_WrData    <= '0;
      RF_WrEn      <= 1'b0;
      RF_RdEn      <= 1'b0;
      TX_P_DATA    <= '0;
      TXDATA_VALID <= 1'b0;
      CMD_BUSY     <= 1'b0;
      FRM_ERR      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      RF_Address   <= addr_n;
      RF_WrData    <= wrdata_n;
      RF_WrEn      <= wren_n;
      RF_RdEn      <= rden_n;
      TX_P_DATA    <= txd_n;
      TXDATA_VALID <= txv_n;
      CMD_BUSY     <= (state_n != IDLE);
      FRM_ERR      <= frm_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder: expected strobes are queued as frames
// are driven and checked by a monitor when the DUT raises them.
module tb_uart_rx_cmd_decoder;
  logic       RX_clk = 1'b0;
  logic       RX_ARST;
  logic [7:0] RX_P_DATA;
  logic       RX_DATA_VLD, RX_PAR_ERR, RX_STP_ERR;
  logic [7:0] RF_RdData;
  logic       RF_RdData_VLD, TX_BUSY;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, TX_P_DATA;
  logic       RF_WrEn, RF_RdEn, TXDATA_VALID, CMD_BUSY, FRM_ERR;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q_wr[$];
  logic [7:0]  q_rd[$];
  logic [7:0]  q_tx[$];
  string       q_frm[$];
  logic [15:0] mon_wr;
  logic [7:0]  mon_b;

  uart_rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
    .RX_clk(RX_clk), .RX_ARST(RX_ARST), .RX_P_DATA(RX_P_DATA), .RX_DATA_VLD(RX_DATA_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR), .RF_RdData(RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD), .TX_BUSY(TX_BUSY), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .TX_P_DATA(TX_P_DATA),
    .TXDATA_VALID(TXDATA_VALID), .CMD_BUSY(CMD_BUSY), .FRM_ERR(FRM_ERR)
  );

  always #5 RX_clk = ~RX_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte strobe; returns 1ns after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b, input logic par, input logic stp);
    @(posedge RX_clk); #1;
    RX_P_DATA = b; RX_DATA_VLD = 1'b1; RX_PAR_ERR = par; RX_STP_ERR = stp;
    @(posedge RX_clk); #1;
    RX_DATA_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge RX_clk);
    #1;
  endtask

  task automatic pulse_rd_data(input logic [7:0] d);
    RF_RdData = d; RF_RdData_VLD = 1'b1;
    @(posedge RX_clk); #1;
    RF_RdData_VLD = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge RX_clk) begin
    if (!RX_ARST) begin
      if (RF_WrEn | RF_RdEn | TXDATA_VALID | FRM_ERR)
        check("strobe_excl", $countones({RF_WrEn, RF_RdEn, TXDATA_VALID, FRM_ERR}), 1);
      if (RF_WrEn) begin
        check("wr_expected", q_wr.size() > 0, 1);
        if (q_wr.size() > 0) begin
          mon_wr = q_wr.pop_front();
          check("wr_addr", RF_Address, mon_wr[11:8]);
          check("wr_data", RF_WrData, mon_wr[7:0]);
        end
      end
      if (RF_RdEn) begin
        check("rd_expected", q_rd.size() > 0, 1);
        if (q_rd.size() > 0) begin
          mon_b = q_rd.pop_front();
          check("rd_addr", RF_Address, mon_b);
        end
      end
      if (TXDATA_VALID) begin
        check("tx_expected", q_tx.size() > 0, 1);
        if (q_tx.size() > 0) begin
          mon_b = q_tx.pop_front();
          check("tx_data", TX_P_DATA, mon_b);
        end
      end
      if (FRM_ERR) begin
        check("frm_expected", q_frm.size() > 0, 1);
        if (q_frm.size() > 0) void'(q_frm.pop_front());
      end
    end
  end

  initial begin
    RX_ARST = 1'b1; RX_P_DATA = '0; RX_DATA_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
    RF_RdData = '0; RF_RdData_VLD = 1'b0; TX_BUSY = 1'b0;
    #1;
    check("rst_outputs", {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TXDATA_VALID, CMD_BUSY, FRM_ERR}, 0);
    step(2);
    RX_ARST = 1'b0;
    step(1);

    // 1: spaced write frame
    send_byte(8'hAA, 0, 0);
    check("t1_busy", CMD_BUSY, 1);
    step(9);
    send_byte(8'h05, 0, 0);
    check("t1_addr_latch", RF_Address, 4'h5);
    step(9);
    q_wr.push_back({4'h0, 4'h5, 8'h3C});
    send_byte(8'h3C, 0, 0);
    check("t1_wren", RF_WrEn, 1);
    check("t1_wrdata", RF_WrData, 8'h3C);
    check("t1_busy_fall", CMD_BUSY, 0);
    step(1);
    check("t1_wren_once", RF_WrEn, 0);
    check("t1_data_hold", RF_WrData, 8'h3C);

    // 2: read round trip, TX busy for 5 cycles after data returns
    TX_BUSY = 1'b1;
    q_rd.push_back(8'h0A);
    q_tx.push_back(8'h77);
    send_byte(8'hBB, 0, 0);
    send_byte(8'h0A, 0, 0);
    check("t2_rden", RF_RdEn, 1);
    check("t2_rd_addr", RF_Address, 4'hA);
    step(2);
    check("t2_rden_once", RF_RdEn, 0);
    pulse_rd_data(8'h77);
    check("t2_txdata", TX_P_DATA, 8'h77);
    step(4);
    check("t2_tx_held", TXDATA_VALID, 0);
    check("t2_busy_wait", CMD_BUSY, 1);
    TX_BUSY = 1'b0;
    step(1);
    check("t2_txvalid", TXDATA_VALID, 1);
    step(1);
    check("t2_txvalid_once", TXDATA_VALID, 0);
    check("t2_txdata_hold", TX_P_DATA, 8'h77);
    check("t2_idle", CMD_BUSY, 0);

    // 3: parity error aborts the write, retry succeeds
    q_frm.push_back("t3_par");
    send_byte(8'hAA, 0, 0);
    send_byte(8'h02, 1, 0);
    check("t3_frm", FRM_ERR, 1);
    check("t3_idle", CMD_BUSY, 0);
    check("t3_addr_hold", RF_Address, 4'hA);
    q_wr.push_back({4'h0, 4'h2, 8'h11});
    send_byte(8'hAA, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h11, 0, 0);
    check("t3_wren", RF_WrEn, 1);

    // 4: silence after address -> timeout 16 cycles after last byte
    send_byte(8'hAA, 0, 0);
    q_frm.push_back("t4_tmo");
    send_byte(8'h03, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k == 15) check("t4_no_early_frm", FRM_ERR, 0);
    end
    check("t4_frm", FRM_ERR, 1);
    check("t4_idle", CMD_BUSY, 0);
    step(1);
    check("t4_frm_once", FRM_ERR, 0);

    // 5: unknown command
    q_frm.push_back("t5_unk");
    send_byte(8'h55, 0, 0);
    check("t5_frm", FRM_ERR, 1);
    check("t5_busy", CMD_BUSY, 0);
    step(1);
    check("t5_frm_once", FRM_ERR, 0);

    // 6: reset mid-frame, then a lone data byte is an unknown command
    send_byte(8'hAA, 0, 0);
    send_byte(8'h01, 0, 0);
    RX_ARST = 1'b1;
    #1;
    check("t6_rst_outputs", {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TXDATA_VALID, CMD_BUSY, FRM_ERR}, 0);
    step(2);
    RX_ARST = 1'b0;
    q_frm.push_back("t6_unk");
    send_byte(8'h44, 0, 0);
    check("t6_frm", FRM_ERR, 1);
    check("t6_no_wr", RF_WrEn, 0);

    // 7: read data on the timeout cycle wins; TX_SEND waits past the timeout
    TX_BUSY = 1'b1;
    q_rd.push_back(8'h06);
    q_tx.push_back(8'h9C);
    send_byte(8'hBB, 0, 0);
    send_byte(8'hF6, 0, 0);
    check("t7_rd_addr_trunc", RF_Address, 4'h6);
    step(15);
    pulse_rd_data(8'h9C);
    check("t7_data_wins", CMD_BUSY, 1);
    check("t7_no_frm", FRM_ERR, 0);
    step(20);
    check("t7_still_waiting", CMD_BUSY, 1);
    TX_BUSY = 1'b0;
    step(1);
    check("t7_txvalid", TXDATA_VALID, 1);

    // 8: accepted byte on the timeout cycle wins
    send_byte(8'hAA, 0, 0);
    send_byte(8'h07, 0, 0);
    step(14);
    q_wr.push_back({4'h0, 4'h7, 8'hE1});
    send_byte(8'hE1, 0, 0);
    check("t8_byte_wins", RF_WrEn, 1);
    check("t8_no_frm", FRM_ERR, 0);

    // 9: stop error in RD_ADDR aborts with no read strobe
    q_frm.push_back("t9_stp");
    send_byte(8'hBB, 0, 0);
    send_byte(8'h09, 0, 1);
    check("t9_frm", FRM_ERR, 1);
    check("t9_no_rd", RF_RdEn, 0);
    step(3);

    check("wr_left", q_wr.size(), 0);
    check("rd_left", q_rd.size(), 0);
    check("tx_left", q_tx.size(), 0);
    check("frm_left", q_frm.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
